acc_out_drain: RTL and testbench

- Downstream consumer of the accumulation output buffer bank.
- Reads a contiguous range of accumulated 16-bit words from the bank's SRAM read port.
- Requantises each word (optional ReLU, rounding arithmetic right shift, saturation to 8 bits).
- Streams results to the next layer's activation writer over a valid/ready interface.
- A small credit-controlled output FIFO absorbs backpressure; no read data is ever dropped.

---
 rtl/acc_out_drain.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_acc_out_drain.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_out_drain.sv
// acc_out_drain: reads a range of accumulator words, requantises them to 8 bits and streams them out.
// Latency: start edge -> rEn next cycle -> FIFO write one cycle later -> out_valid the cycle after that.
// Backpressure: reads are issued only while FIFO occupancy plus the in-flight read leaves a free slot, so no read data is lost.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start, base_addr, length,       job launch pulse and job parameters (latched in IDLE)
//   shift, relu_en
//   rEn, rAddr, rData               buffer bank read port (rData valid one cycle after rEn)
//   out_data, out_valid, out_ready  requantised activation stream (valid/ready)
//   busy, done                      job status; done pulses once per completed job

// Small generic synchronous FIFO used as the output buffer.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push is dropped when full, pop is ignored when empty; the caller's credit logic prevents both.
//
// Ports:
//   push/push_data  write side
//   pop             advance the head
//   head/count      current head word and occupancy (both registered state)
module acc_out_drain_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [width-1:0]         push_data,
  input  logic                     pop,
  output logic [width-1:0]         head,
  output logic [$clog2(depth):0]   count
);

  localparam int pw = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [pw-1:0]    wr_ptr;
  logic [pw-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != (pw+1)'(depth));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Storage has no reset; the head is only used while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + pw'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + pw'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (pw+1)'(1);
        2'b01:   count <= count - (pw+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

module acc_out_drain #(
  parameter int buffer_width      = 16,
  parameter int buffer_depth      = 8192,
  parameter int buffer_addr_width = $clog2(buffer_depth),
  parameter int out_width         = 8,
  parameter int shift_width       = 4,
  parameter int fifo_depth        = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [buffer_addr_width-1:0]  base_addr,
  input  logic [buffer_addr_width:0]    length,
  input  logic [shift_width-1:0]        shift,
  input  logic                          relu_en,
  output logic                          rEn,
  output logic [buffer_addr_width-1:0]  rAddr,
  input  logic [buffer_width-1:0]       rData,
  output logic [out_width-1:0]          out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          done
);

  localparam int aw    = buffer_addr_width;
  localparam int cnt_w = $clog2(fifo_depth) + 1;

  localparam logic [aw-1:0] last_addr = aw'(buffer_depth - 1);

  // Saturation bounds expressed in the widened requantisation width.
  localparam logic signed [buffer_width:0] sat_hi = (buffer_width+1)'(2**(out_width-1) - 1);
  localparam logic signed [buffer_width:0] sat_lo = (buffer_width+1)'(-(2**(out_width-1)));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Job context, latched at start.
  logic [aw-1:0]          addr_q;
  logic [aw:0]            remain_q;
  logic [shift_width-1:0] shift_q;
  logic                   relu_q;

  // One read can be outstanding: its data arrives the cycle after rEn.
  logic                   inflight;

  logic [cnt_w-1:0]       fifo_count;
  logic [out_width-1:0]   fifo_head;
  logic [out_width-1:0]   quant;

  logic                   credit_ok;
  logic                   issue;
  logic                   drained;
  logic                   last_issue;

  // Reserve a slot for the read already in flight so that its data always
  // finds room in the FIFO regardless of what the consumer does.
  assign credit_ok  = ({1'b0, fifo_count} + {{cnt_w{1'b0}}, inflight}) < (cnt_w+1)'(fifo_depth);
  assign issue      = (state == READ) && (remain_q != '0) && credit_ok;
  assign last_issue = issue && (remain_q == (aw+1)'(1));
  assign drained    = !inflight && (fifo_count == '0);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (length == '0) ? FLUSH : READ;
        end
      end
      READ: begin
        if (last_issue) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (drained) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  // busy drops in the same cycle done pulses, so a zero-length job never
  // shows busy at all.
  always_comb begin
    rEn  = 1'b0;
    done = 1'b0;
    busy = 1'b0;
    case (state)
      READ: begin
        rEn  = issue;
        busy = 1'b1;
      end
      FLUSH: begin
        done = drained;
        busy = !drained;
      end
      default: begin
        rEn  = 1'b0;
        done = 1'b0;
        busy = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Job context and read address generation
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      remain_q <= '0;
      shift_q  <= '0;
      relu_q   <= 1'b0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (state == IDLE && start) begin
        addr_q   <= base_addr;
        remain_q <= length;
        shift_q  <= shift;
        relu_q   <= relu_en;
      end else if (issue) begin
        // Explicit wrap keeps the address legal for non power-of-two depths.
        addr_q   <= (addr_q == last_addr) ? '0 : addr_q + aw'(1);
        remain_q <= remain_q - (aw+1)'(1);
      end
    end
  end

  assign rAddr = addr_q;

  // ---------------------------------------------------------------------
  // Requantisation of the returning read word
  // ---------------------------------------------------------------------
  logic signed [buffer_width-1:0] x_raw;
  logic signed [buffer_width:0]   x_ext;
  logic signed [buffer_width:0]   rnd;
  logic signed [buffer_width:0]   y;

  // One extra bit of headroom keeps x + 2^(shift-1) from overflowing before
  // the shift; >>> on a signed operand gives floor, so adding half rounds
  // ties toward +infinity.
  always_comb begin
    x_raw = $signed(rData);
    if (relu_q && (x_raw < 0)) begin
      x_raw = '0;
    end
    x_ext = {x_raw[buffer_width-1], x_raw};
    rnd   = '0;
    y     = x_ext;
    if (shift_q != '0) begin
      rnd = {{buffer_width{1'b0}}, 1'b1} << (shift_q - shift_width'(1));
      y   = (x_ext + rnd) >>> shift_q;
    end
    if (y > sat_hi) begin
      quant = sat_hi[out_width-1:0];
    end else if (y < sat_lo) begin
      quant = sat_lo[out_width-1:0];
    end else begin
      quant = y[out_width-1:0];
    end
  end

  // ---------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------
  acc_out_drain_fifo #(
    .width (out_width),
    .depth (fifo_depth)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (quant),
    .pop       (out_valid && out_ready),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // Valid and data come straight from FIFO state; out_ready only affects
  // the pop, never the current cycle's valid.
  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? fifo_head : '0;

endmodule

// File: tb/tb_acc_out_drain.sv
module tb_acc_out_drain;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic [3:0]    shift;
  logic          relu_en;
  logic          rEn;
  logic [AW-1:0] rAddr;
  logic [15:0]   rData;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  acc_out_drain dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .shift     (shift),
    .relu_en   (relu_en),
    .rEn       (rEn),
    .rAddr     (rAddr),
    .rData     (rData),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Buffer bank model: one-cycle read latency.
  logic [15:0] bank [0:8191];
  always @(posedge clk) begin
    if (rEn) rData <= bank[rAddr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor, sampled on the falling edge.
  int rd_addr_q[$];
  int rd_cyc_q[$];
  int out_q[$];
  int out_cyc_q[$];
  int done_cyc_q[$];
  int first_valid_cyc;
  int rd_total;
  int pop_total;
  int max_out;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rEn) begin
        rd_addr_q.push_back(int'(rAddr));
        rd_cyc_q.push_back(cyc);
        rd_total++;
      end
      if (rd_total - pop_total > max_out) max_out = rd_total - pop_total;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        out_q.push_back(int'($signed(out_data)));
        out_cyc_q.push_back(cyc);
        pop_total++;
      end
      if (done) done_cyc_q.push_back(cyc);
    end
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -9999;
  endfunction

  task automatic clear_mon();
    rd_addr_q.delete();
    rd_cyc_q.delete();
    out_q.delete();
    out_cyc_q.delete();
    done_cyc_q.delete();
    first_valid_cyc = -1;
    rd_total        = 0;
    pop_total       = 0;
    max_out         = 0;
  endtask

  // Drives a one-cycle start; sc is the cycle index in which start is high.
  task automatic launch(input int b, input int l, input int s, input bit r, output int sc);
    @(posedge clk); #1;
    base_addr = AW'(b);
    length    = (AW+1)'(l);
    shift     = 4'(s);
    relu_en   = r;
    start     = 1'b1;
    sc        = cyc;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done_cyc_q.size() == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_done_seen"}, (done_cyc_q.size() != 0) ? 1 : 0, 1);
  endtask

  typedef struct {
    int          shift;
    bit          relu;
    logic [15:0] rdata;
    int          expv;
  } vec_t;

  vec_t vecs[18];

  initial begin : wdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int sc;
    int dummy;

    vecs[0]  = '{0, 1'b0, 16'h0005, 5};
    vecs[1]  = '{0, 1'b0, 16'hFFFA, -6};
    vecs[2]  = '{0, 1'b0, 16'h0064, 100};
    vecs[3]  = '{0, 1'b0, 16'hFF9C, -100};
    vecs[4]  = '{4, 1'b0, 16'h0105, 16};
    vecs[5]  = '{1, 1'b0, 16'hFFFD, -1};
    vecs[6]  = '{1, 1'b0, 16'h0003, 2};
    vecs[7]  = '{0, 1'b0, 16'h7FFF, 127};
    vecs[8]  = '{0, 1'b0, 16'h8000, -128};
    vecs[9]  = '{0, 1'b1, 16'h8000, 0};
    vecs[10] = '{2, 1'b1, 16'h0006, 2};
    vecs[11] = '{15, 1'b0, 16'h7FFF, 1};
    vecs[12] = '{15, 1'b0, 16'h8000, -1};
    vecs[13] = '{8, 1'b0, 16'h4000, 64};
    vecs[14] = '{3, 1'b0, 16'hFFEC, -2};
    vecs[15] = '{1, 1'b0, 16'hFFFF, 0};
    vecs[16] = '{0, 1'b1, 16'hFFFF, 0};
    vecs[17] = '{0, 1'b0, 16'h00C8, 127};

    for (int i = 0; i < 8192; i++) bank[i] = 16'h0000;
    clear_mon();

    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    shift     = '0;
    relu_en   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rEn", int'(rEn), 0);
    check("rst_rAddr", int'(rAddr), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic stream
    bank[16] = 16'h0005; bank[17] = 16'hFFFA; bank[18] = 16'h0064; bank[19] = 16'hFF9C;
    clear_mon();
    launch(16, 4, 0, 1'b0, sc);
    check("basic_busy", int'(busy), 1);
    wait_done(50, "basic");
    repeat (4) @(posedge clk);
    #1;
    check("basic_nreads", rd_total, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("basic_addr%0d", i), qget(rd_addr_q, i), 16 + i);
      check($sformatf("basic_rcyc%0d", i), qget(rd_cyc_q, i), sc + 1 + i);
    end
    check("basic_first_valid", first_valid_cyc, sc + 3);
    check("basic_out0", qget(out_q, 0), 5);
    check("basic_out1", qget(out_q, 1), -6);
    check("basic_out2", qget(out_q, 2), 100);
    check("basic_out3", qget(out_q, 3), -100);
    check("basic_nouts", out_q.size(), 4);
    check("basic_done_cyc", qget(done_cyc_q, 0), qget(out_cyc_q, 3) + 1);
    check("basic_ndone", done_cyc_q.size(), 1);
    check("basic_idle_busy", int'(busy), 0);

    // Requantisation table: one single-word job per vector
    for (int i = 0; i < 18; i++) begin
      bank[1000 + i] = vecs[i].rdata;
      clear_mon();
      launch(1000 + i, 1, vecs[i].shift, vecs[i].relu, sc);
      wait_done(50, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_out", i), qget(out_q, 0), vecs[i].expv);
      repeat (2) @(posedge clk);
    end

    // Backpressure: 20 words, consumer stalled for 10 cycles
    for (int i = 0; i < 20; i++) bank[300 + i] = 16'(i * 3 - 30);
    clear_mon();
    out_ready = 1'b0;
    launch(300, 20, 0, 1'b0, sc);
    repeat (10) @(posedge clk);
    #1;
    check("bp_reads_stalled", rd_total, 4);
    check("bp_valid_stalled", int'(out_valid), 1);
    out_ready = 1'b1;
    wait_done(200, "bp");
    check("bp_max_outstanding", max_out, 4);
    check("bp_nouts", out_q.size(), 20);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("bp_out%0d", i), qget(out_q, i), i * 3 - 30);
    end
    repeat (2) @(posedge clk);

    // Address wrap
    bank[8190] = 16'd1; bank[8191] = 16'd2; bank[0] = 16'd3; bank[1] = 16'd4;
    clear_mon();
    launch(8190, 4, 0, 1'b0, sc);
    wait_done(50, "wrap");
    check("wrap_addr0", qget(rd_addr_q, 0), 8190);
    check("wrap_addr1", qget(rd_addr_q, 1), 8191);
    check("wrap_addr2", qget(rd_addr_q, 2), 0);
    check("wrap_addr3", qget(rd_addr_q, 3), 1);
    check("wrap_out2", qget(out_q, 2), 3);
    repeat (2) @(posedge clk);

    // Zero length
    clear_mon();
    launch(50, 0, 0, 1'b0, sc);
    wait_done(20, "zero");
    repeat (3) @(posedge clk);
    #1;
    check("zero_nreads", rd_total, 0);
    check("zero_done_cyc", qget(done_cyc_q, 0), sc + 1);
    check("zero_ndone", done_cyc_q.size(), 1);

    // Start while busy is ignored
    for (int i = 0; i < 4; i++) bank[400 + i] = 16'(7 + i);
    bank[500] = 16'd77; bank[501] = 16'd78;
    clear_mon();
    launch(400, 4, 0, 1'b0, sc);
    launch(500, 2, 3, 1'b1, dummy);
    wait_done(50, "busy_start");
    repeat (10) @(posedge clk);
    #1;
    check("busy_start_nreads", rd_total, 4);
    check("busy_start_addr3", qget(rd_addr_q, 3), 403);
    check("busy_start_ndone", done_cyc_q.size(), 1);
    check("busy_start_nouts", out_q.size(), 4);
    check("busy_start_out3", qget(out_q, 3), 10);

    // Reset mid-job with two entries buffered
    for (int i = 0; i < 20; i++) bank[600 + i] = 16'(i + 1);
    clear_mon();
    out_ready = 1'b0;
    launch(600, 20, 0, 1'b0, sc);
    repeat (3) @(posedge clk);
    #1;
    check("mid_valid_before", int'(out_valid), 1);
    check("mid_head_before", int'($signed(out_data)), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rEn", int'(rEn), 0);
    check("mid_rst_rAddr", int'(rAddr), 0);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_data", int'(out_data), 0);
    check("mid_rst_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    clear_mon();
    repeat (20) @(posedge clk);
    #1;
    check("mid_no_done", done_cyc_q.size(), 0);
    check("mid_no_reads", rd_total, 0);
    check("mid_no_outs", out_q.size(), 0);

    bank[700] = 16'h0123; bank[701] = 16'hFFF8; bank[702] = 16'h1000;
    clear_mon();
    launch(700, 3, 2, 1'b0, sc);
    wait_done(50, "post");
    check("post_addr0", qget(rd_addr_q, 0), 700);
    check("post_addr2", qget(rd_addr_q, 2), 702);
    check("post_out0", qget(out_q, 0), 73);
    check("post_out1", qget(out_q, 1), -2);
    check("post_out2", qget(out_q, 2), 127);
    check("post_first_valid", first_valid_cyc, sc + 3);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
